multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, register file, instruction/data memory port and immediate generator across FETCH/DECODE/EXECUTE/MEM/WB states, one instruction at a time. It drives the immediate generator's 3-bit format select (000 I, 001 S, 010 B, 011 J, 100 U) and stalls on a req/ready memory handshake.

---
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I core.
// Sequences the shared ALU, register file, memory port and immediate
// generator one instruction at a time. It waits on a req/ready memory
// handshake for every access.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   opcode, funct3    fields of the instruction register
//   zero              ALU zero flag, current cycle
//   mem_ready         memory accepts/completes the access this cycle
//   mem_req/mem_write memory request and store qualifier
//   adr_src           0: address = PC, 1: address = ALUOut
//   ir_write          load instruction register and oldPC
//   pc_write          PC enable (fetch update or taken branch/jal)
//   reg_write         register file write enable
//   alu_src_a/b       ALU operand selects
//   alu_op            00 add, 01 sub, 10 funct decode
//   result_src        00 ALUOut, 01 memory data, 10 ALU result
//   imm_src           immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   instr_done        pulse on the last cycle of a retiring instruction
//   illegal_instr     pulse in DECODE for an unsupported opcode
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= oldPC + imm (branch/jump target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | load access at ALUOut
// MEMWB    | rd <= loaded data
// MEMWRITE | store access at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// JAL      | PC <= target, ALUOut <= oldPC + 4
// LUI      | ALUOut <= 0 + imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= target if taken
module multicycle_ctrl #(
  parameter bit BNE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_LUI      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t     state_q, state_d;
  logic       taken;
  logic [2:0] imm_dec;
  logic       unused_funct3;

  // funct3[2:1] never matter to this controller; funct3[0] only with BNE_EN.
  assign unused_funct3 = ^funct3;
  assign taken = BNE_EN ? (zero ^ funct3[0]) : zero;

  always_comb begin
    imm_dec = 3'b000;
    case (opcode)
      OP_SW:   imm_dec = 3'b001;
      OP_BR:   imm_dec = 3'b010;
      OP_JAL:  imm_dec = 3'b011;
      OP_LUI:  imm_dec = 3'b100;
      default: imm_dec = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    imm_src       = 3'b000;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = imm_dec;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = imm_dec;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        imm_src = imm_dec;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        imm_src    = imm_dec;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        imm_src    = imm_dec;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        imm_src   = imm_dec;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        imm_src   = imm_dec;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        imm_src   = imm_dec;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = imm_dec;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        imm_src    = imm_dec;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = taken;
        instr_done = 1'b1;
        imm_src    = imm_dec;
      end
      default: state_d = S_FETCH;
    endcase

    // The state register already sits at FETCH during reset; force the
    // outputs quiet so nothing is requested or written while held.
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      result_src    = 2'b00;
      imm_src       = 3'b000;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // index 1: BNE_EN=1 instance, index 0: BNE_EN=0 instance
  logic [1:0]      mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]      instr_done, illegal_instr;
  logic [1:0][1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [1:0][2:0] imm_src;
  logic [18:0]     ov1, ov0;

  int checks = 0;
  int errors = 0;
  int stores = 0;

  logic [18:0] e1_q[$], e0_q[$], o1_q[$], o0_q[$];
  bit          rdy_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.BNE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req[1]), .mem_write(mem_write[1]),
    .adr_src(adr_src[1]), .ir_write(ir_write[1]), .pc_write(pc_write[1]),
    .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
    .alu_op(alu_op[1]), .result_src(result_src[1]), .imm_src(imm_src[1]),
    .instr_done(instr_done[1]), .illegal_instr(illegal_instr[1])
  );

  multicycle_ctrl #(.BNE_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req[0]), .mem_write(mem_write[0]),
    .adr_src(adr_src[0]), .ir_write(ir_write[0]), .pc_write(pc_write[0]),
    .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
    .alu_op(alu_op[0]), .result_src(result_src[0]), .imm_src(imm_src[0]),
    .instr_done(instr_done[0]), .illegal_instr(illegal_instr[0])
  );

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,op,res,imm,done,ill}
  assign ov1 = {mem_req[1], mem_write[1], adr_src[1], ir_write[1], pc_write[1],
                reg_write[1], alu_src_a[1], alu_src_b[1], alu_op[1], result_src[1],
                imm_src[1], instr_done[1], illegal_instr[1]};
  assign ov0 = {mem_req[0], mem_write[0], adr_src[0], ir_write[0], pc_write[0],
                reg_write[0], alu_src_a[0], alu_src_b[0], alu_op[0], result_src[0],
                imm_src[0], instr_done[0], illegal_instr[0]};

  always @(posedge clk)
    if (rst_n && mem_req[1] && mem_write[1] && mem_ready) stores++;

  function automatic logic [18:0] mk(input logic mreq, mw, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, op, rs,
                                     input logic [2:0] imm, input logic done, ill);
    return {mreq, mw, adr, irw, pcw, rw, a, b, op, rs, imm, done, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  task automatic push2(input logic [18:0] e1, input logic [18:0] e0, input bit r);
    e1_q.push_back(e1);
    e0_q.push_back(e0);
    rdy_q.push_back(r);
  endtask

  // Reference: expected per-cycle output vectors of one instruction, written
  // from the per-phase output table; nf/nm are fetch/memory wait cycles.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int nf, input int nm);
    logic [2:0]  im;
    logic [18:0] v, wb;
    im = imm_of(op);
    e1_q.delete(); e0_q.delete(); rdy_q.delete();
    for (int i = 0; i <= nf; i++) begin
      v = mk(1, 0, 0, i == nf, i == nf, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
      push2(v, v, i == nf);
    end
    wb = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1, 0);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111, 7'b0110111: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, im, 0, 0);
        push2(v, v, 0);
      end
      default: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, im, 0, 1);
        push2(v, v, 0);
      end
    endcase
    case (op)
      7'b0000011: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, im, 0, 0);
        push2(v, v, 0);
        for (int i = 0; i <= nm; i++) begin
          v = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0, 0);
          push2(v, v, i == nm);
        end
        v = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, im, 1, 0);
        push2(v, v, 0);
      end
      7'b0100011: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, im, 0, 0);
        push2(v, v, 0);
        for (int i = 0; i <= nm; i++) begin
          v = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, i == nm, 0);
          push2(v, v, i == nm);
        end
      end
      7'b0110011: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0, 0);
        push2(v, v, 0); push2(wb, wb, 0);
      end
      7'b0010011: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, im, 0, 0);
        push2(v, v, 0); push2(wb, wb, 0);
      end
      7'b1101111: begin
        v = mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, im, 0, 0);
        push2(v, v, 0); push2(wb, wb, 0);
      end
      7'b0110111: begin
        v = mk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, im, 0, 0);
        push2(v, v, 0); push2(wb, wb, 0);
      end
      7'b1100011: begin
        push2(mk(0, 0, 0, 0, z ^ f3[0], 0, 2'b10, 2'b00, 2'b01, 2'b00, im, 1, 0),
              mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 2'b00, im, 1, 0), 0);
      end
      default: ;
    endcase
  endtask

  // Drives n cycles from the ready queue; starts and ends at posedge+1.
  task automatic replay(input int n);
    o1_q.delete(); o0_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q[i];
      #4;
      o1_q.push_back(ov1);
      o0_q.push_back(ov0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic z, input int nf, input int nmw);
    opcode = op; funct3 = f3; zero = z;
    build(op, f3, z, nf, nmw);
    replay(e1_q.size());
    for (int i = 0; i < e1_q.size(); i++) begin
      checks++;
      if (o1_q[i] !== e1_q[i]) begin
        errors++;
        $display("FAIL %s cyc%0d bne_en1 got %h exp %h", nm, i, o1_q[i], e1_q[i]);
      end
      checks++;
      if (o0_q[i] !== e0_q[i]) begin
        errors++;
        $display("FAIL %s cyc%0d bne_en0 got %h exp %h", nm, i, o0_q[i], e0_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [18:0] fv;
    fv = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    #2;
    checks++;
    if (ov1 !== 19'd0 || ov0 !== 19'd0) begin
      errors++; $display("FAIL reset_init got %h/%h exp 0", ov1, ov0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    #4;
    checks++;
    if (ov1 !== fv || ov0 !== fv) begin
      errors++; $display("FAIL reset_first_fetch got %h/%h exp %h", ov1, ov0, fv);
    end
    @(posedge clk); #1;
    // abandon a stalled store
    opcode = 7'b0100011; funct3 = 3'b010; zero = 1'b0;
    build(7'b0100011, 3'b010, 1'b0, 0, 5);
    replay(4);
    checks++;
    if (o1_q[3] !== e1_q[3]) begin
      errors++; $display("FAIL reset_pre_memwrite got %h exp %h", o1_q[3], e1_q[3]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ov1 !== 19'd0 || ov0 !== 19'd0) begin
      errors++; $display("FAIL reset_async got %h/%h exp 0", ov1, ov0);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ov1 !== 19'd0 || ov0 !== 19'd0) begin
        errors++; $display("FAIL reset_hold got %h/%h exp 0", ov1, ov0);
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; rst_n = 1'b1;
    #4;
    checks++;
    if (ov1 !== fv || ov0 !== fv) begin
      errors++; $display("FAIL reset_refetch got %h/%h exp %h", ov1, ov0, fv);
    end
    @(posedge clk); #1;
    checks++;
    if (stores !== 0) begin
      errors++; $display("FAIL reset_no_store got %0d exp 0", stores);
    end
  endtask

  task automatic test_lw();
    int rw_at, rw_n;
    test_instr("lw", 7'b0000011, 3'b010, 1'b0, 0, 0);
    rw_at = -1; rw_n = 0;
    foreach (o1_q[i]) if (o1_q[i][13]) begin rw_at = i; rw_n++; end
    checks++;
    if (rw_n !== 1 || rw_at !== 4) begin
      errors++; $display("FAIL lw_reg_write got n=%0d at %0d exp n=1 at 4", rw_n, rw_at);
    end
  endtask

  task automatic test_sw_stall();
    int held, done_n, st0;
    st0 = stores;
    test_instr("sw_stall", 7'b0100011, 3'b010, 1'b0, 0, 3);
    held = 0; done_n = 0;
    foreach (o1_q[i]) begin
      if (o1_q[i][18:16] == 3'b111) held++;
      if (o1_q[i][1]) done_n++;
    end
    checks++;
    if (held !== 4 || done_n !== 1) begin
      errors++; $display("FAIL sw_hold got held=%0d done=%0d exp 4 1", held, done_n);
    end
    checks++;
    if (stores - st0 !== 1) begin
      errors++; $display("FAIL sw_store_count got %0d exp 1", stores - st0);
    end
  endtask

  task automatic test_branch();
    test_instr("beq_z1", 7'b1100011, 3'b000, 1'b1, 0, 0);
    test_instr("bne_z1", 7'b1100011, 3'b001, 1'b1, 0, 0);
    test_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1, 0);
    test_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 0, 0);
  endtask

  task automatic test_alu_jal_lui();
    test_instr("r_type", 7'b0110011, 3'b000, 1'b0, 0, 0);
    test_instr("i_type", 7'b0010011, 3'b111, 1'b1, 2, 0);
    test_instr("jal", 7'b1101111, 3'b000, 1'b0, 0, 0);
    test_instr("lui", 7'b0110111, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    test_instr("illegal", 7'b1111111, 3'b000, 1'b0, 0, 0);
    test_instr("illegal_wait", 7'b0000000, 3'b101, 1'b1, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    logic [6:0] op;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111};
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 8);
      op = (k == 8) ? 7'($urandom) : ops[k];
      test_instr("random", op, 3'($urandom), 1'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_alu_jal_lui();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
